// File: rtl/bram_pkg.sv
// Shared BRAM definitions: default geometry and the stream reader FSM encoding.
package bram_pkg;

  localparam int RAM_WIDTH_DEF     = 16;
  localparam int RAM_ADDR_BITS_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that absorbs BRAM read data while the downstream stalls.
module skid_fifo2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_p0 [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage stage: payload is not reset, emptiness is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) mem_p0[wr_ptr_q] <= din;
  end

  assign dout  = (count_q != 2'd0) ? mem_p0[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Streams len consecutive BRAM words starting at base_addr onto a valid/ready port.
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [RAM_ADDR_BITS:0]   len,
  output logic                     busy,
  output logic                     done,
  output logic [RAM_ADDR_BITS-1:0] bram_addr,
  output logic                     bram_en,
  output logic                     bram_we,
  input  logic [RAM_WIDTH-1:0]     bram_dout,
  output logic [RAM_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int LEN_W = RAM_ADDR_BITS + 1;

  rd_state_t                state_q;
  logic [LEN_W-1:0]         rd_left_q;
  logic [LEN_W-1:0]         xfer_left_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic                     rd_vld_p1;
  logic                     zero_done_q;

  logic [1:0] fifo_count;
  logic [1:0] occ_sum;
  logic       xfer;
  logic       space;
  logic       rd_issue;
  logic       last_xfer;

  assign xfer      = out_valid & out_ready;
  assign occ_sum   = fifo_count + {1'b0, rd_vld_p1};
  // A pop in this cycle frees the slot that a full FIFO plus in-flight read would need
  assign space     = (occ_sum < 2'd2) || ((occ_sum == 2'd2) && xfer);
  assign rd_issue  = (state_q == ST_READ) && (rd_left_q != '0) && space;
  assign last_xfer = (state_q == ST_DRAIN) && xfer && (xfer_left_q == LEN_W'(1));

  assign bram_en   = rd_issue;
  assign bram_addr = addr_q;
  assign bram_we   = 1'b0;
  assign busy      = (state_q != ST_IDLE) || zero_done_q;
  assign done      = zero_done_q | last_xfer;

  // Issue stage: address generation and command FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_left_q   <= '0;
      xfer_left_q <= '0;
      addr_q      <= '0;
      rd_vld_p1   <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      rd_vld_p1   <= rd_issue;
      zero_done_q <= 1'b0;
      if (xfer) xfer_left_q <= xfer_left_q - LEN_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (start && !zero_done_q) begin
            if (len != '0) begin
              state_q     <= ST_READ;
              rd_left_q   <= len;
              xfer_left_q <= len;
              addr_q      <= base_addr;
            end else begin
              zero_done_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (rd_issue) begin
            addr_q    <= addr_q + RAM_ADDR_BITS'(1);
            rd_left_q <= rd_left_q - LEN_W'(1);
            if (rd_left_q == LEN_W'(1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_xfer) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Capture stage: registered BRAM data lands in the FIFO one cycle after bram_en
  skid_fifo2 #(
    .DATA_W(RAM_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rd_vld_p1),
    .din  (bram_dout),
    .pop  (xfer),
    .dout (out_data),
    .count(fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);

endmodule
